// File: rtl/edit_mem_buf_req_arb_pkg.sv
// rtl/edit_mem_buf_req_arb_pkg.sv - shared edit-mem constants and requester tag type
// Contents:
//   EM_BUF_PTR_NBITS  default buffer pointer width
//   EM_LL_ACK_LAT     cycles from buf_req to buf_ack_valid in the linked list
//   em_tag_t          requester tag, sized for the largest supported NREQ (8)
//   em_tag_onehot     tag -> one-hot requester select
package edit_mem_buf_req_arb_pkg;
    localparam int EM_BUF_PTR_NBITS = 8;
    localparam int EM_LL_ACK_LAT    = 4;
    localparam int EM_TAG_NBITS_MAX = 3;

    typedef logic [EM_TAG_NBITS_MAX-1:0] em_tag_t;

    function automatic logic [7:0] em_tag_onehot(input em_tag_t tag);
        return 8'd1 << tag;
    endfunction
endpackage

// File: rtl/edit_mem_buf_req_arb_if.sv
// rtl/edit_mem_buf_req_arb_if.sv - requester/linked-list lookup bus of the buf_req arbiter
// Signals:
//   req_valid/req_ptr/req_ready       requester lookup handshake (one-hot ready)
//   ack_valid/ack_ptr                 next pointer routed back to the issuing requester
//   buf_req/buf_req_ptr               lookup strobe towards the linked list
//   buf_ack_valid/buf_ack_ptr         lookup return from the linked list
//   rc_pending                        read-count walker has work
//   err_unexp_ack                     sticky unexpected-ack flag
// Modports: slave = arbiter, master = requesters + linked list side.
interface edit_mem_buf_req_arb_if
    import edit_mem_buf_req_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int BPTR_NBITS = EM_BUF_PTR_NBITS
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*BPTR_NBITS-1:0] req_ptr;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            ack_valid;
    logic [BPTR_NBITS-1:0]      ack_ptr;
    logic                       buf_req;
    logic [BPTR_NBITS-1:0]      buf_req_ptr;
    logic                       buf_ack_valid;
    logic [BPTR_NBITS-1:0]      buf_ack_ptr;
    logic                       rc_pending;
    logic                       err_unexp_ack;

    modport slave (
        input  req_valid, req_ptr, buf_ack_valid, buf_ack_ptr, rc_pending,
        output req_ready, ack_valid, ack_ptr, buf_req, buf_req_ptr, err_unexp_ack
    );

    modport master (
        output req_valid, req_ptr, buf_ack_valid, buf_ack_ptr, rc_pending,
        input  req_ready, ack_valid, ack_ptr, buf_req, buf_req_ptr, err_unexp_ack
    );
endinterface

// File: rtl/edit_mem_buf_req_arb_rr_arb.sv
// rtl/edit_mem_buf_req_arb_rr_arb.sv - generic NREQ round-robin picker (module em_rr_arb)
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (rr_ptr <- 0)
//   i_req          request vector
//   i_en           grant enable; no grant and rr_ptr holds when low
//   o_gnt          one-hot grant, first set i_req bit searching up from rr_ptr
//   o_idx          index of the picked requester
module em_rr_arb #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_en,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx
);
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_pick_idx;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;
    logic             w_grant;

    // Modular add that also works for non power-of-two NREQ.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= NREQ) j = j - NREQ;
        return IDX_W'(j);
    endfunction

    always_comb begin
        w_found    = 1'b0;
        w_pick_idx = '0;
        w_cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = wrap_add(r_rr_ptr, k);
            if (!w_found && i_req[w_cand]) begin
                w_found    = 1'b1;
                w_pick_idx = w_cand;
            end
        end
    end

    assign w_grant = i_en && w_found;
    assign o_gnt   = w_grant ? (NREQ'(1) << w_pick_idx) : '0;
    assign o_idx   = w_pick_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= wrap_add(w_pick_idx, 1);
        end
    end
endmodule

// File: rtl/sfifo2f_fo.sv
// rtl/sfifo2f_fo.sv - synchronous show-ahead FIFO (head word always on o_data)
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data    write; ignored when full
//   i_pop             read; ignored when empty
//   o_data            current head entry (valid when !o_empty)
//   o_empty, o_full   occupancy flags
module sfifo2f_fo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/edit_mem_buf_req_arb.sv
// rtl/edit_mem_buf_req_arb.sv - round-robin sharing of the linked-list next-pointer lookup port
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   bus            edit_mem_buf_req_arb_if.slave (requesters + linked-list lookup port)
// Optional feature (macro EM_LL_RC_GAP_EN): after RC_GAP consecutive grants with
// rc_pending high, one grant-free cycle lets the read-count walker advance.
module edit_mem_buf_req_arb
    import edit_mem_buf_req_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int BPTR_NBITS = EM_BUF_PTR_NBITS,
    parameter int MAX_OUT    = 6,
    parameter int TAG_DEPTH  = 8,
    parameter int RC_GAP     = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    edit_mem_buf_req_arb_if.slave  bus
);
    localparam int TAG_W = $clog2(NREQ);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic [OUT_W-1:0]      r_outstanding;
    logic                  r_buf_req;
    logic [BPTR_NBITS-1:0] r_buf_req_ptr;
    logic [NREQ-1:0]       r_ack_valid;
    logic [BPTR_NBITS-1:0] r_ack_ptr;
    logic                  r_err_unexp_ack;

    logic                  w_gate_open;
    logic                  w_credit_ok;
    logic [NREQ-1:0]       w_gnt;
    logic [TAG_W-1:0]      w_gnt_idx;
    logic                  w_grant;
    logic [BPTR_NBITS-1:0] w_sel_ptr;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_tag_empty;
    logic                  w_tag_full_unused;
    logic                  w_pop;
    logic [NREQ-1:0]       w_ack_onehot;

    // Only the registered count is checked, so an ack arriving this cycle
    // cannot be spent on a grant until the next cycle.
    assign w_credit_ok = (r_outstanding < OUT_W'(MAX_OUT));

    em_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (TAG_W)
    ) u_rr_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (bus.req_valid),
        .i_en  (w_credit_ok && w_gate_open),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx)
    );

    assign w_grant   = |w_gnt;
    assign w_sel_ptr = bus.req_ptr[w_gnt_idx*BPTR_NBITS +: BPTR_NBITS];

    // The credit limit keeps the tag FIFO from overflowing (TAG_DEPTH >= MAX_OUT).
    sfifo2f_fo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_grant),
        .i_data  (w_gnt_idx),
        .i_pop   (w_pop),
        .o_data  (w_tag),
        .o_empty (w_tag_empty),
        .o_full  (w_tag_full_unused)
    );

    // Acks with no tag to pair are dropped; this keeps outstanding from underflowing.
    assign w_pop        = bus.buf_ack_valid && !w_tag_empty;
    assign w_ack_onehot = NREQ'(em_tag_onehot(em_tag_t'(w_tag)));

`ifdef EM_LL_RC_GAP_EN
    localparam int GAP_W = $clog2(RC_GAP + 1);

    logic [GAP_W-1:0] r_gap_cnt;

    assign w_gate_open = (r_gap_cnt != GAP_W'(RC_GAP));

    // A closed gate forces a grant-free cycle, which clears the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gap_cnt <= '0;
        end else if (w_grant && bus.rc_pending) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end
`else
    localparam int w_unused_rc_gap = RC_GAP;
    logic w_unused_rc_pending;

    assign w_gate_open         = 1'b1;
    assign w_unused_rc_pending = bus.rc_pending;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_outstanding   <= '0;
            r_buf_req       <= 1'b0;
            r_buf_req_ptr   <= '0;
            r_ack_valid     <= '0;
            r_ack_ptr       <= '0;
            r_err_unexp_ack <= 1'b0;
        end else begin
            r_buf_req   <= w_grant;
            r_ack_valid <= w_pop ? w_ack_onehot : '0;
            if (w_grant) r_buf_req_ptr <= w_sel_ptr;
            if (w_pop)   r_ack_ptr     <= bus.buf_ack_ptr;
            if (bus.buf_ack_valid && w_tag_empty) r_err_unexp_ack <= 1'b1;
            case ({w_grant, w_pop})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign bus.req_ready     = w_gnt;
    assign bus.buf_req       = r_buf_req;
    assign bus.buf_req_ptr   = r_buf_req_ptr;
    assign bus.ack_valid     = r_ack_valid;
    assign bus.ack_ptr       = r_ack_ptr;
    assign bus.err_unexp_ack = r_err_unexp_ack;
endmodule

// File: tb/tb_edit_mem_buf_req_arb.sv
// tb/tb_edit_mem_buf_req_arb.sv - self-checking bench for edit_mem_buf_req_arb
module tb_edit_mem_buf_req_arb;
    import edit_mem_buf_req_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int PW   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    edit_mem_buf_req_arb_if #(.NREQ(NREQ), .BPTR_NBITS(PW)) bus ();

    edit_mem_buf_req_arb #(
        .NREQ       (NREQ),
        .BPTR_NBITS (PW),
        .MAX_OUT    (6),
        .TAG_DEPTH  (8),
        .RC_GAP     (8)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int            due;
        logic [PW-1:0] ptr;
    } ll_ent_t;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] exp_ready;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat   = EM_LL_ACK_LAT;
    logic inject = 1'b0;

    ll_ent_t         ll_q[$];
    logic [NREQ-1:0] exp_ack_q[$];
    logic [PW-1:0]   rp [NREQ] = '{8'h03, 8'h47, 8'h1A, 8'h5C};

    logic [NREQ-1:0] o_ready, o_ackv;
    logic            o_bufreq, o_err;
    logic [PW-1:0]   o_bufptr, o_ackptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] ptr_of(input logic [NREQ-1:0] oh);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) if (oh[i]) r = rp[i];
        return r;
    endfunction

    task automatic exp_grant(input logic [NREQ-1:0] oh);
        if (oh != '0) exp_ack_q.push_back(oh);
    endtask

    // One clock: the linked-list model drives buf_ack, outputs are sampled
    // mid-cycle, then the clock edge is taken.
    task automatic step();
        logic [NREQ-1:0] e;
        bus.buf_ack_valid = 1'b0;
        bus.buf_ack_ptr   = '0;
        if (ll_q.size() > 0 && ll_q[0].due <= cyc) begin
            bus.buf_ack_valid = 1'b1;
            bus.buf_ack_ptr   = ll_q[0].ptr;
            void'(ll_q.pop_front());
        end else if (inject) begin
            bus.buf_ack_valid = 1'b1;
            bus.buf_ack_ptr   = 8'h77;
        end
        #2;
        o_ready  = bus.req_ready;
        o_ackv   = bus.ack_valid;
        o_bufreq = bus.buf_req;
        o_bufptr = bus.buf_req_ptr;
        o_ackptr = bus.ack_ptr;
        o_err    = bus.err_unexp_ack;
        if (o_bufreq) ll_q.push_back('{cyc + lat, o_bufptr + 8'h11});
        if (o_ackv != '0) begin
            if (exp_ack_q.size() == 0) begin
                chk("spurious_ack_valid", 32'(o_ackv), 32'd0);
            end else begin
                e = exp_ack_q.pop_front();
                chk("ack_order", 32'(o_ackv), 32'(e));
                chk("ack_ptr", 32'(o_ackptr), 32'(ptr_of(e) + 8'h11));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int n);
        bus.req_valid = '0;
        repeat (n) step();
    endtask

    initial begin
        vec_t            tv[12];
        logic [NREQ-1:0] prev;
        logic [NREQ-1:0] e;
        int              g;
        logic            idle;

        tv[0]  = '{4'b1111, 4'b1000};
        tv[1]  = '{4'b1111, 4'b0001};
        tv[2]  = '{4'b0101, 4'b0100};
        tv[3]  = '{4'b0101, 4'b0001};
        tv[4]  = '{4'b0000, 4'b0000};
        tv[5]  = '{4'b0001, 4'b0001};
        tv[6]  = '{4'b1000, 4'b1000};
        tv[7]  = '{4'b0110, 4'b0010};
        tv[8]  = '{4'b0110, 4'b0100};
        tv[9]  = '{4'b0011, 4'b0001};
        tv[10] = '{4'b1010, 4'b0010};
        tv[11] = '{4'b1001, 4'b1000};

        rst               = 1'b1;
        bus.req_valid     = '0;
        bus.req_ptr       = {rp[3], rp[2], rp[1], rp[0]};
        bus.buf_ack_valid = 1'b0;
        bus.buf_ack_ptr   = '0;
        bus.rc_pending    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        step();
        chk("rst_req_ready", 32'(o_ready), 32'd0);
        chk("rst_ack_valid", 32'(o_ackv), 32'd0);
        chk("rst_buf_req", 32'(o_bufreq), 32'd0);
        chk("rst_buf_req_ptr", 32'(o_bufptr), 32'd0);
        chk("rst_ack_ptr", 32'(o_ackptr), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);

        // Single request: grant T, buf_req T+1, list ack T+5, ack_valid T+6
        bus.req_valid = 4'b0100;
        step();
        chk("single_grant", 32'(o_ready), 32'h4);
        exp_grant(4'b0100);
        bus.req_valid = '0;
        step();
        chk("single_buf_req", 32'(o_bufreq), 32'd1);
        chk("single_buf_req_ptr", 32'(o_bufptr), 32'h1A);
        repeat (3) step();
        step();
        chk("single_no_early_ack", 32'(o_ackv), 32'd0);
        step();
        chk("single_ack_valid", 32'(o_ackv), 32'h4);
        chk("single_ack_ptr", 32'(o_ackptr), 32'h2B);
        drain(3);

        // Table of round-robin selections (rr_ptr starts at 3)
        prev = '0;
        for (int k = 0; k < 12; k++) begin
            bus.req_valid = tv[k].req;
            step();
            chk($sformatf("tbl%0d_ready", k), 32'(o_ready), 32'(tv[k].exp_ready));
            exp_grant(tv[k].exp_ready);
            if (prev != '0) begin
                chk($sformatf("tbl%0d_buf_req", k), 32'(o_bufreq), 32'd1);
                chk($sformatf("tbl%0d_buf_req_ptr", k), 32'(o_bufptr), 32'(ptr_of(prev)));
            end else begin
                chk($sformatf("tbl%0d_buf_req_idle", k), 32'(o_bufreq), 32'd0);
            end
            prev = tv[k].exp_ready;
        end
        drain(8);

        // All requesters valid for 12 cycles: 0,1,2,3,... with no bubbles
        for (int k = 0; k < 12; k++) begin
            bus.req_valid = 4'b1111;
            step();
            e = 4'b0001 << (k % 4);
            chk($sformatf("sust%0d_ready", k), 32'(o_ready), 32'(e));
            exp_grant(e);
            if (k > 0) chk($sformatf("sust%0d_buf_req", k), 32'(o_bufreq), 32'd1);
        end
        drain(8);

        // Credit limit with slow list: 6 grants, stall, first ack frees one grant
        lat = 10;
        for (int k = 0; k < 13; k++) begin
            bus.req_valid = 4'b1111;
            step();
            if (k < 6)       e = 4'b0001 << (k % 4);
            else if (k == 12) e = 4'b0100;
            else             e = 4'b0000;
            chk($sformatf("credit%0d_ready", k), 32'(o_ready), 32'(e));
            exp_grant(e);
        end
        drain(16);
        lat = EM_LL_ACK_LAT;

        // Grant together with an ack at outstanding=5 keeps the pipe going
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = 4'b1111;
            step();
            e = 4'b0001 << ((3 + k) % 4);
            chk($sformatf("simul%0d_ready", k), 32'(o_ready), 32'(e));
            exp_grant(e);
        end
        drain(8);

        // Unexpected ack: sticky error, no ack_valid, outstanding stays 0
        inject = 1'b1;
        step();
        inject = 1'b0;
        step();
        chk("unexp_err", 32'(o_err), 32'd1);
        chk("unexp_no_ack_valid", 32'(o_ackv), 32'd0);
        step();
        step();
        chk("unexp_err_sticky", 32'(o_err), 32'd1);
        lat = 10;
        for (int k = 0; k < 7; k++) begin
            bus.req_valid = 4'b1111;
            step();
            e = (k < 6) ? (4'b0001 << ((3 + k) % 4)) : 4'b0000;
            chk($sformatf("unexp_credit%0d_ready", k), 32'(o_ready), 32'(e));
            exp_grant(e);
        end
        drain(16);
        lat = EM_LL_ACK_LAT;

        // rc_pending held high with everyone valid (rr_ptr starts at 1)
        bus.rc_pending = 1'b1;
        g = 0;
        for (int k = 0; k < 18; k++) begin
            bus.req_valid = 4'b1111;
            step();
`ifdef EM_LL_RC_GAP_EN
            idle = ((k % 9) == 8);
`else
            idle = 1'b0;
`endif
            e = idle ? 4'b0000 : (4'b0001 << ((1 + g) % 4));
            if (!idle) g++;
            chk($sformatf("gap%0d_ready", k), 32'(o_ready), 32'(e));
            exp_grant(e);
        end
        bus.rc_pending = 1'b0;
        drain(8);

        chk("all_acks_returned", 32'(exp_ack_q.size()), 32'd0);
        chk("final_err_sticky", 32'(o_err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/edit_mem_buf_req_arb.md
# edit_mem_buf_req_arb

Round-robin arbiter and sequencer that shares the single next-pointer lookup port of the edit-memory buffer linked list (buf_req / buf_ack) between NREQ requesters, such as the per-port dequeue engines. It grants at most one lookup per cycle and caps the number of lookups in flight with a credit counter. It tags each issued lookup with its requester index and routes each returned buf_ack_ptr back to the requester that issued it, in order. Optionally, it inserts idle cycles so that the linked list's read-count walker, which stalls whenever buf_req is active, keeps making progress.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8).
- BPTR_NBITS, `EM_BUF_PTR_NBITS: buffer pointer width.
- MAX_OUT, 6: maximum lookups in flight. 6 sustains one grant per cycle.
- TAG_DEPTH, 8: tag FIFO depth. Must be ≥ MAX_OUT.
- RC_GAP, 8: maximum consecutive grants while rc_pending is high (macro feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset. One clock domain; reset polarity and synchronicity are fixed.
- req_valid  in  NREQ  per-requester lookup request.
- req_ptr  in  NREQ*BPTR_NBITS  current buffer pointer. Requester i occupies slice [i*BPTR_NBITS +: BPTR_NBITS].
- req_ready  out  NREQ  one-hot grant. Combinational from req_valid and registered state.
- ack_valid  out  NREQ  one-hot; the next pointer is returned to the flagged requester.
- ack_ptr  out  BPTR_NBITS  next buffer pointer.
- buf_req  out  1  lookup strobe to the linked list.
- buf_req_ptr  out  BPTR_NBITS  pointer to look up.
- buf_ack_valid  in  1  lookup return from the linked list.
- buf_ack_ptr  in  BPTR_NBITS  looked-up next pointer.
- rc_pending  in  1  the read-count walker has work. Used only with the macro feature; ignored otherwise.
- err_unexp_ack  out  1  sticky flag: buf_ack_valid arrived while the tag FIFO was empty.

## Operation

- Grant condition: any req_valid is set AND outstanding < MAX_OUT AND the gap gate is open.
- Selection: the first set bit of req_valid, searching from rr_ptr upward with wrap-around.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - On a transfer, rr_ptr ← (i+1) mod NREQ. Without a transfer, rr_ptr holds.
- On a grant of requester i:
  - register buf_req=1 and buf_req_ptr=req_ptr[i];
  - push tag i into the tag FIFO;
  - increment outstanding.
- On buf_ack_valid:
  - pop the tag;
  - register ack_valid=onehot(tag) and ack_ptr=buf_ack_ptr;
  - decrement outstanding.
- If a grant and an ack occur in the same cycle, outstanding is unchanged.
- A grant does not use the same-cycle ack to bypass the limit: it checks the registered count only.
- Acks always return in order. The linked list has a fixed latency, so no reordering is possible.
- Unexpected ack (buf_ack_valid while the tag FIFO is empty):
  - set err_unexp_ack;
  - drop the ack;
  - outstanding stays at 0 and never underflows.
- outstanding is $clog2(MAX_OUT+1) bits wide and saturates at neither end. The MAX_OUT check guarantees the tag FIFO never overflows.
- req_ptr must stay stable while req_valid is set until the transfer.

## Timing

- Grant (transfer) in cycle T.
- buf_req asserted in T+1.
- The linked list returns buf_ack_valid in T+5.
- ack_valid asserted in T+6.
- Throughput: one grant per cycle sustained with the default MAX_OUT.
- Reset values: req_ready=0, ack_valid=0, buf_req=0, buf_req_ptr=0, ack_ptr=0, err_unexp_ack=0, rr_ptr=0, outstanding=0, tag FIFO empty, gap counter=0.
- Reset mid-operation discards all in-flight tags. The linked list is reset on the same rst, so no stale acks are expected; any that do arrive set err_unexp_ack.

## Configuration

- Macro: EM_LL_RC_GAP_EN.
- Defined:
  - a gap counter counts consecutive grant cycles while rc_pending=1;
  - when the count reaches RC_GAP, the gate closes for exactly one cycle (no grant) and the counter clears;
  - the counter also clears on any cycle without a grant or with rc_pending=0.
- Undefined: the gate is always open, rc_pending is unused, and the gap counter is not instantiated.

## Structure

- Shared package (edit-mem package): the tag type (width $clog2(NREQ)) and the ack-latency constant EM_LL_ACK_LAT=4, which is the latency from buf_req to buf_ack_valid.
- Tag FIFO: reuse sfifo2f_fo with width $clog2(NREQ) and depth TAG_DEPTH.
- Natural sub-module: em_rr_arb, a generic NREQ round-robin picker with rr_ptr state and a one-hot grant output.

## Test plan

- Single request: req_valid=4'b0100, req_ptr[2]=0x1A in T.
  - Expect buf_req with buf_req_ptr=0x1A in T+1.
  - The list model returns 0x2B in T+5.
  - Expect ack_valid=4'b0100, ack_ptr=0x2B in T+6.
- All 4 requesters held valid for 12 cycles:
  - expect grants in order 0,1,2,3,0,1,… with one grant per cycle and no bubbles;
  - acks return in the same order.
- Credit limit: the list model holds acks for 10 cycles.
  - Exactly 6 grants, then req_ready=0.
  - The first ack releases exactly one further grant in the next cycle.
- Simultaneous grant and ack at outstanding=5: outstanding stays 5, and a grant is allowed in the next cycle.
- Inject buf_ack_valid with no prior request: err_unexp_ack=1 and sticky, ack_valid stays 0, outstanding stays 0.
- With EM_LL_RC_GAP_EN and RC_GAP=8, rc_pending=1, all requesters valid: one idle buf_req cycle after every 8 grants. With the macro undefined: no idle cycles.
